// File: rtl/gps_nav_core.sv
// rtl/gps_nav_core.sv - multi-channel GPS epoch averager with sequential restoring divider
// Define GPS_NAV_JUMP_DET_EN to compile in the position-jump alert; otherwise alert is tied low.
module gps_nav_core #(
  parameter int CH           = 4,
  parameter int W            = 32,
  parameter int EPOCH_CYCLES = 64,
  parameter int JUMP_THR     = 1000,
  parameter int ALERT_HOLD   = 8,
  localparam int CW          = $clog2(CH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [CH-1:0]   ch_valid,
  input  logic [CH*W-1:0] ch_pos,
  input  logic [CH*W-1:0] ch_vel,
  output logic [W-1:0]    position,
  output logic [W-1:0]    velocity,
  output logic [CW-1:0]   fix_count,
  output logic            fix_valid,
  output logic            out_valid,
  output logic            overrun,
  output logic            alert
);
  localparam int SW  = W + CW;
  localparam int ECW = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;
  localparam int CIW = (CH > 1) ? $clog2(CH) : 1;
  localparam int IW  = $clog2(SW + 1);

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_DIV, S_PUB} state_t;

  state_t          state_q, state_d;
  logic [ECW-1:0]  ep_cnt_q, ep_cnt_d;
  logic [W-1:0]    live_pos_q [CH], live_pos_d [CH], live_vel_q [CH], live_vel_d [CH];
  logic [W-1:0]    sh_pos_q [CH], sh_pos_d [CH], sh_vel_q [CH], sh_vel_d [CH];
  logic [CH-1:0]   live_seen_q, live_seen_d, sh_seen_q, sh_seen_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d, prem_q, prem_d, vrem_q, vrem_d, prem_n, vrem_n;
  logic [SW-1:0]   psum_q, psum_d, vsum_q, vsum_d, psum_n, vsum_n;
  logic [W-1:0]    position_q, position_d, velocity_q, velocity_d;
  logic [CW-1:0]   fix_count_q, fix_count_d;
  logic            fix_valid_q, fix_valid_d, out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic            epoch_end;
  logic [CIW-1:0]  sel;

  // One restoring step: remainder and quotient share a left shift, quotient bit enters at the LSB.
  function automatic logic [CW+SW-1:0] div_step(input logic [CW-1:0] rem, input logic [SW-1:0] q,
                                                input logic [CW-1:0] d);
    logic [CW:0] sh;
    logic        ge;
    sh = {rem, q[SW-1]};
    ge = (sh >= {1'b0, d});
    return {ge ? CW'(sh - {1'b0, d}) : sh[CW-1:0], q[SW-2:0], ge};
  endfunction

  assign epoch_end = enable && (ep_cnt_q == ECW'(EPOCH_CYCLES - 1));
  assign sel       = idx_q[CIW-1:0];

  always_comb begin
    ep_cnt_d    = (!enable || epoch_end) ? '0 : ep_cnt_q + 1'b1;
    live_pos_d  = live_pos_q;
    live_vel_d  = live_vel_q;
    live_seen_d = (!enable || epoch_end) ? '0 : live_seen_q;
    for (int c = 0; c < CH; c++) begin
      if (enable && ch_valid[c]) begin
        live_pos_d[c]  = ch_pos[c*W +: W];
        live_vel_d[c]  = ch_vel[c*W +: W];
        live_seen_d[c] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_pos_d    = sh_pos_q;
    sh_vel_d    = sh_vel_q;
    sh_seen_d   = sh_seen_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    psum_d      = psum_q;
    vsum_d      = vsum_q;
    prem_d      = prem_q;
    vrem_d      = vrem_q;
    position_d  = position_q;
    velocity_d  = velocity_q;
    fix_count_d = fix_count_q;
    fix_valid_d = fix_valid_q;
    out_valid_d = 1'b0;
    overrun_d   = epoch_end && (state_q != S_IDLE);
    {prem_n, psum_n} = div_step(prem_q, psum_q, cnt_q);
    {vrem_n, vsum_n} = div_step(vrem_q, vsum_q, cnt_q);
    case (state_q)
      S_IDLE: begin
        if (epoch_end) begin
          sh_pos_d  = live_pos_q;
          sh_vel_d  = live_vel_q;
          sh_seen_d = live_seen_q;
          idx_d     = '0;
          cnt_d     = '0;
          psum_d    = '0;
          vsum_d    = '0;
          state_d   = S_SUM;
        end
      end
      S_SUM: begin
        if (sh_seen_q[sel]) begin
          psum_d = psum_q + SW'(sh_pos_q[sel]);
          vsum_d = vsum_q + SW'(sh_vel_q[sel]);
          cnt_d  = cnt_q + 1'b1;
        end
        if (idx_q == IW'(CH - 1)) begin
          idx_d  = '0;
          prem_d = '0;
          vrem_d = '0;
          if (cnt_d == '0) begin
            state_d     = S_PUB;
            out_valid_d = 1'b1;
            fix_valid_d = 1'b0;
            fix_count_d = '0;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DIV: begin
        psum_d = psum_n;
        vsum_d = vsum_n;
        prem_d = prem_n;
        vrem_d = vrem_n;
        if (idx_q == IW'(SW - 1)) begin
          state_d     = S_PUB;
          position_d  = psum_n[W-1:0];
          velocity_d  = vsum_n[W-1:0];
          fix_count_d = cnt_q;
          fix_valid_d = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_PUB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    live_pos_q <= live_pos_d;
    live_vel_q <= live_vel_d;
    sh_pos_q   <= sh_pos_d;
    sh_vel_q   <= sh_vel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ep_cnt_q    <= '0;
      live_seen_q <= '0;
      sh_seen_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      psum_q      <= '0;
      vsum_q      <= '0;
      prem_q      <= '0;
      vrem_q      <= '0;
      position_q  <= '0;
      velocity_q  <= '0;
      fix_count_q <= '0;
      fix_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ep_cnt_q    <= ep_cnt_d;
      live_seen_q <= live_seen_d;
      sh_seen_q   <= sh_seen_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      psum_q      <= psum_d;
      vsum_q      <= vsum_d;
      prem_q      <= prem_d;
      vrem_q      <= vrem_d;
      position_q  <= position_d;
      velocity_q  <= velocity_d;
      fix_count_q <= fix_count_d;
      fix_valid_q <= fix_valid_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign position  = position_q;
  assign velocity  = velocity_q;
  assign fix_count = fix_count_q;
  assign fix_valid = fix_valid_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

`ifdef GPS_NAV_JUMP_DET_EN
  localparam int HW = $clog2(ALERT_HOLD + 1);

  logic [W-1:0]  prev_q, prev_d, jump;
  logic          prev_vld_q, prev_vld_d;
  logic [HW-1:0] hold_q, hold_d;

  // The new fix is visible on position_q during PUBLISH, so the compare runs there.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    hold_d     = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    jump       = (position_q >= prev_q) ? position_q - prev_q : prev_q - position_q;
    if (state_q == S_PUB && fix_valid_q) begin
      if (prev_vld_q && (jump > W'(JUMP_THR))) hold_d = HW'(ALERT_HOLD);
      prev_d     = position_q;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign alert = (hold_q != '0);
`else
  // Detector parameters stay referenced even though the detector is compiled out.
  if (JUMP_THR < 0 || ALERT_HOLD < 0) begin : g_param_guard
  end
  assign alert = 1'b0;
`endif
endmodule

// File: tb/tb_gps_nav_core.sv
// tb/tb_gps_nav_core.sv - directed self-checking bench for gps_nav_core
module tb_gps_nav_core;
  localparam int CH = 4;
  localparam int W  = 32;
  localparam int CW = 3;
`ifdef GPS_NAV_JUMP_DET_EN
  localparam logic JD = 1'b1;
`else
  localparam logic JD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, rst2, enable;
  logic [CH-1:0]   ch_valid;
  logic [CH*W-1:0] ch_pos, ch_vel;
  logic [W-1:0]    position, velocity, position2, velocity2;
  logic [CW-1:0]   fix_count, fix_count2;
  logic            fix_valid, out_valid, overrun, alert;
  logic            fix_valid2, out_valid2, overrun2, alert2;
  int              cyc, nvec, nerr;

  always #5 clk = ~clk;

  gps_nav_core #(.CH(CH), .W(W), .EPOCH_CYCLES(64), .JUMP_THR(1000), .ALERT_HOLD(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_valid(ch_valid), .ch_pos(ch_pos), .ch_vel(ch_vel),
    .position(position), .velocity(velocity), .fix_count(fix_count), .fix_valid(fix_valid),
    .out_valid(out_valid), .overrun(overrun), .alert(alert)
  );

  gps_nav_core #(.CH(CH), .W(W), .EPOCH_CYCLES(30), .JUMP_THR(1000), .ALERT_HOLD(8)) u_dut_short (
    .clk(clk), .rst(rst2), .enable(1'b1), .ch_valid(ch_valid), .ch_pos(ch_pos), .ch_vel(ch_vel),
    .position(position2), .velocity(velocity2), .fix_count(fix_count2), .fix_valid(fix_valid2),
    .out_valid(out_valid2), .overrun(overrun2), .alert(alert2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic strobe(input int t, input int c, input logic [W-1:0] p, input logic [W-1:0] v);
    go_to(t);
    ch_valid            = '0;
    ch_valid[c]         = 1'b1;
    ch_pos[c*W +: W]    = p;
    ch_vel[c*W +: W]    = v;
    tick();
    ch_valid            = '0;
  endtask

  task automatic pub(input string tag, input int t, input logic [W-1:0] p, input logic [W-1:0] v,
                     input int fc, input logic fv);
    go_to(t - 1);
    chk({tag, "_ov_before"}, out_valid, 0);
    tick();
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_pos"}, position, p);
    chk({tag, "_vel"}, velocity, v);
    chk({tag, "_cnt"}, fix_count, fc);
    chk({tag, "_fv"}, fix_valid, fv);
    tick();
    chk({tag, "_ov_after"}, out_valid, 0);
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    rst = 1'b1; rst2 = 1'b1; enable = 1'b1;
    ch_valid = '0; ch_pos = '0; ch_vel = '0;
    repeat (3) tick();
    chk("rst_pos", position, 0);
    chk("rst_vel", velocity, 0);
    chk("rst_cnt", fix_count, 0);
    chk("rst_fv", fix_valid, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_alert", alert, 0);
    rst = 1'b0;
    cyc = 0;

    // epoch 1 ends at cycle 63: four channels, 1001/4 and 19/4 truncate
    go_to(10);
    ch_valid = 4'hf;
    ch_pos = {32'd401, 32'd300, 32'd200, 32'd100};
    ch_vel = {32'd7, 32'd4, 32'd4, 32'd4};
    tick();
    ch_valid = '0;
    go_to(64);
    chk("e1_no_overrun", overrun, 0);
    strobe(80, 2, 32'd7777, 32'd55);
    pub("e1", 103, 32'd250, 32'd4, 4, 1'b1);
    chk("e1_alert", alert, 0);

    // epoch 2 ends at 127: single channel; big jump from 250
    pub("e2", 167, 32'd7777, 32'd55, 1, 1'b1);
    chk("e2_alert_rise", alert, JD);
    go_to(175);
    chk("e2_alert_last", alert, JD);
    go_to(176);
    chk("e2_alert_fall", alert, 0);

    // epoch 3 ends at 191 with no samples
    pub("e3", 196, 32'd7777, 32'd55, 0, 1'b0);

    // epoch 4 ends at 255: last in-epoch sample wins, epoch-end sample carries over
    strobe(200, 0, 32'd10, 32'd1);
    strobe(220, 0, 32'd20, 32'd2);
    strobe(255, 0, 32'd30, 32'd3);
    pub("e4", 295, 32'd20, 32'd2, 1, 1'b1);
    chk("e4_alert", alert, JD);
    pub("e5", 359, 32'd30, 32'd3, 1, 1'b1);
    chk("e5_alert", alert, 0);

    // alert threshold pairs: 1000->2000 and 2000->1000 stay quiet, 1000->2001 fires
    strobe(365, 1, 32'd1000, 32'd0);
    pub("e6", 423, 32'd1000, 32'd0, 1, 1'b1);
    chk("e6_alert", alert, 0);
    strobe(430, 3, 32'd2000, 32'd5);
    pub("e7", 487, 32'd2000, 32'd5, 1, 1'b1);
    chk("e7_alert", alert, 0);
    strobe(495, 2, 32'd1000, 32'd6);
    pub("e8", 551, 32'd1000, 32'd6, 1, 1'b1);
    chk("e8_alert", alert, 0);
    strobe(560, 1, 32'd2001, 32'd12);

    // enable drops mid-division: fix still publishes, partial epoch 10 is discarded
    strobe(578, 0, 32'd999, 32'd9);
    go_to(580);
    enable = 1'b0;
    go_to(614);
    chk("e9_alert_pre", alert, 0);
    pub("e9", 615, 32'd2001, 32'd12, 1, 1'b1);
    chk("e9_alert_rise", alert, JD);
    go_to(620);
    enable = 1'b1;
    go_to(623);
    chk("e9_alert_last", alert, JD);
    go_to(624);
    chk("e9_alert_fall", alert, 0);
    pub("e10", 688, 32'd2001, 32'd12, 0, 1'b0);

    // short-epoch instance: overrun on second epoch end, then reset mid-division
    go_to(700);
    rst2 = 1'b0;
    strobe(705, 1, 32'd500, 32'd9);
    go_to(759);
    chk("s_overrun_pre", overrun2, 0);
    tick();
    chk("s_overrun", overrun2, 1);
    tick();
    chk("s_overrun_post", overrun2, 0);
    go_to(768);
    chk("s_ov_pre", out_valid2, 0);
    tick();
    chk("s_ov", out_valid2, 1);
    chk("s_pos", position2, 500);
    chk("s_vel", velocity2, 9);
    chk("s_cnt", fix_count2, 1);
    strobe(770, 0, 32'd1234, 32'd3);
    go_to(790);
    chk("s_no_overrun", overrun2, 0);
    go_to(800);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk("s_rst_pos", position2, 0);
    chk("s_rst_vel", velocity2, 0);
    chk("s_rst_cnt", fix_count2, 0);
    chk("s_rst_fv", fix_valid2, 0);
    while (cyc < 835) begin
      chk("s_abort_no_ov", out_valid2, 0);
      tick();
    end
    chk("s_empty_ov", out_valid2, 1);
    chk("s_empty_fv", fix_valid2, 0);
    chk("s_empty_pos", position2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/gps_nav_core.md
# gps_nav_core

Parametrised multi-channel GPS navigation core, the next generation of the GPS top-level datapath. It samples CH independent receiver channels over fixed-length epochs and computes an averaged position/velocity fix per epoch with a sequential divider. A built-in position-jump detector raises a timed alert, and the block replaces the single-channel interface → processor → detector chain under the FPGA top.

## Interface
Parameters:
- CH, 4, number of receiver channels (1–16)
- W, 32, position/velocity width, unsigned
- EPOCH_CYCLES, 64, clock cycles per epoch
- JUMP_THR, 1000, position step (unsigned) above which alert fires
- ALERT_HOLD, 8, cycles alert stays high after a trigger

Ports:
- clk  in  1  system clock; sole clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run epochs when high
- ch_valid  in  CH  per-channel sample strobe
- ch_pos  in  CH*W  channel c position at bits [c*W +: W]
- ch_vel  in  CH*W  channel c velocity, same packing
- position  out  W  averaged position of last valid fix
- velocity  out  W  averaged velocity of last valid fix
- fix_count  out  CW=clog2(CH+1)  channels contributing to last epoch
- fix_valid  out  1  last epoch had ≥1 channel
- out_valid  out  1  one-cycle pulse, epoch result published
- overrun  out  1  one-cycle pulse, epoch dropped because core busy
- alert  out  1  jump alert

## Operation
- Live registers per channel (pos, vel, seen). On a ch_valid cycle, sample stored and seen set; the last sample in an epoch wins.
- Epoch counter runs 0..EPOCH_CYCLES-1 while enable=1. At count EPOCH_CYCLES-1 (epoch end):
  - If FSM is IDLE, copy live registers to shadow registers and start FSM.
  - Otherwise, pulse overrun and discard that epoch.
  - Clear all live seen flags in either case. A ch_valid on the epoch-end cycle is captured into live registers for the next epoch, not the shadow.
- FSM states:
  - IDLE → SUM: at epoch end.
  - SUM, CH cycles: channel i added in cycle i if shadow seen. Sums use SW=W+CW bits with no overflow. Count increments per seen channel.
  - SUM → DIV, or SUM → PUBLISH when count=0.
  - DIV, SW cycles: restoring division of both sums by count in parallel; quotient truncated. The low W bits are the result, and they always fit.
  - DIV → PUBLISH.
  - PUBLISH, 1 cycle:
    - count>0: update position/velocity, set fix_valid=1, set fix_count=count, then run the jump check against the previous fix if one exists.
    - count=0: set fix_valid=0, set fix_count=0, hold position/velocity, skip the jump check.
    - out_valid pulses in both cases. PUBLISH → IDLE.
- Jump check: alert triggers when |new - prev| > JUMP_THR (strict). Alert is then high for exactly ALERT_HOLD cycles. A retrigger during hold reloads the counter.
- enable low:
  - Epoch counter held at 0 and live seen flags cleared; partial epoch discarded.
  - An in-flight FSM computation completes and publishes.
  - Alert hold keeps counting.
- Reset values:
  - position, velocity, fix_count, fix_valid, out_valid, overrun, alert: all 0.
  - FSM returns to IDLE; all counters and seen flags cleared.
  - "Previous fix exists" flag cleared.
  - Reset mid-computation aborts it with no publish.

## Timing
- Epoch end at cycle E; SUM occupies E+1..E+CH; DIV occupies the next SW cycles; PUBLISH follows.
- Outputs update and out_valid pulses at E+CH+SW+1 when count>0, and at E+CH+1 when count=0.
- Alert rises in the cycle after PUBLISH.
- Required: EPOCH_CYCLES > CH+SW+1. If violated, the overrun rule applies.

## Configuration
- GPS_NAV_JUMP_DET_EN:
  - Defined: jump detector, previous-fix register and alert hold counter compiled in, as described above.
  - Undefined: that logic is absent and alert is tied to 0. All other behaviour and timing are unchanged.

## Test plan
All scenarios use CH=4, W=32, EPOCH_CYCLES=64, JUMP_THR=1000, ALERT_HOLD=8, so SW=35.
- Reset held for 3 cycles, enable=1 → all outputs 0, then out_valid first pulses 40 cycles after the first epoch end.
- Channels 0–3 each give pos 100/200/300/401 and vel 4/4/4/7 in one epoch → position=250, velocity=4, fix_count=4, fix_valid=1.
- Only channel 2 valid, pos 7777 → position=7777, fix_count=1. A following epoch with no samples → fix_valid=0, position still 7777, out_valid pulses 5 cycles after epoch end.
- Consecutive fixes 1000 then 2001 → alert high for exactly 8 cycles. Fixes 1000 then 2000 → alert stays 0. Macro undefined → alert always 0.
- Channel 0 strobes 10 then 20 within an epoch, then 30 on the epoch-end cycle → published position 20; 30 appears in the next epoch.
- EPOCH_CYCLES=30 → overrun pulses at the second epoch end. rst asserted mid-DIV → no out_valid, outputs 0.
